// File: rtl/exec_if.sv
// Operation/result bundle between the ID/EX pipeline register, hazard
// control and the execute-stage arithmetic unit.
interface exec_if #(
    parameter int WIDTH = 32
) ();

    logic             valid_i;   // operation presented this cycle
    logic [3:0]       ctrl_i;    // ALU control code
    logic [WIDTH-1:0] a_i;       // operand A (rs1)
    logic [WIDTH-1:0] b_i;       // operand B (rs2 or immediate)
    logic             kill_i;    // pipeline flush
    logic [WIDTH-1:0] result_o;  // registered result
    logic             zero_o;    // registered (result == 0)
    logic             done_o;    // result_o/zero_o updated this cycle
    logic             busy_o;    // stall request while mul iterates

    // Pipeline side: presents operations, observes results.
    modport master (
        output valid_i, ctrl_i, a_i, b_i, kill_i,
        input  result_o, zero_o, done_o, busy_o
    );

    // Execute unit side.
    modport slave (
        input  valid_i, ctrl_i, a_i, b_i, kill_i,
        output result_o, zero_o, done_o, busy_o
    );

endinterface

// File: rtl/exec_unit.sv
// Execute-stage arithmetic unit of the RV32 pipeline. Single-cycle ops
// (and/xor/sll/add/sub/sra) produce a registered result one edge after
// acceptance; mul runs a fixed-latency shift-add engine of MUL_STEPS
// iterations and holds busy_o high so IF/ID/EX freeze while it runs.
// MUL_STEPS must equal WIDTH for the product to be complete.
module exec_unit #(
    parameter int WIDTH     = 32,
    parameter int MUL_STEPS = 32
) (
    input  logic    clk_i,
    input  logic    rst_i,
    exec_if.slave   bus
);

    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int STEP_W  = $clog2(MUL_STEPS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(MUL_STEPS - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_XOR = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;
    localparam logic [3:0] OP_MUL = 4'b0101;
    localparam logic [3:0] OP_SRA = 4'b0110;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_MUL  = 1'b1
    } state_e;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------

    // Single-cycle result; undefined codes yield zero so zero_o reads 1.
    function automatic logic [WIDTH-1:0] alu_result(
        input logic [3:0]       op,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b
    );
        logic [SHAMT_W-1:0] sh;
        logic [WIDTH-1:0]   r;
        sh = b[SHAMT_W-1:0];
        case (op)
            OP_AND:  r = a & b;
            OP_XOR:  r = a ^ b;
            OP_SLL:  r = a << sh;
            OP_ADD:  r = a + b;
            OP_SUB:  r = a - b;
            OP_SRA:  r = WIDTH'($signed(a) >>> sh);
            default: r = {WIDTH{1'b0}};
        endcase
        return r;
    endfunction

    // Branch-compare flag.
    function automatic logic is_zero(input logic [WIDTH-1:0] v);
        return (v == {WIDTH{1'b0}});
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e             state_q,  state_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               zero_q,   zero_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   mcand_q,  mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [WIDTH-1:0]   acc_q,    acc_d;
    logic [STEP_W-1:0]  step_q,   step_d;

    // Accumulator value after the current shift-add iteration.
    logic [WIDTH-1:0]   acc_step_s;

    // One shift-add iteration: add multiplicand when multiplier LSB is set.
    always_comb begin
        if (mplier_q[0]) begin
            acc_step_s = acc_q + mcand_q;
        end else begin
            acc_step_s = acc_q;
        end
    end

    // Next-state and datapath: kill beats any new operation, MUL ignores valid_i.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        done_d   = 1'b0;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        step_d   = step_q;

        if (bus.kill_i) begin
            // Flush: drop any in-flight mul and any op presented now.
            state_d = S_IDLE;
            step_d  = {STEP_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (bus.valid_i) begin
                        if (bus.ctrl_i == OP_MUL) begin
                            mcand_d  = bus.a_i;
                            mplier_d = bus.b_i;
                            acc_d    = {WIDTH{1'b0}};
                            step_d   = {STEP_W{1'b0}};
                            state_d  = S_MUL;
                        end else begin
                            result_d = alu_result(bus.ctrl_i, bus.a_i, bus.b_i);
                            zero_d   = is_zero(result_d);
                            done_d   = 1'b1;
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end

                S_MUL: begin
                    acc_d    = acc_step_s;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    step_d   = step_q + {{(STEP_W-1){1'b0}}, 1'b1};
                    if (step_q == LAST_STEP) begin
                        // Fixed latency: finish only on the final step count.
                        result_d = acc_step_s;
                        zero_d   = is_zero(acc_step_s);
                        done_d   = 1'b1;
                        step_d   = {STEP_W{1'b0}};
                        state_d  = S_IDLE;
                    end else begin
                        state_d  = S_MUL;
                    end
                end

                default: begin
                    state_d = S_IDLE;
                    step_d  = {STEP_W{1'b0}};
                end
            endcase
        end
    end

    // State and output registers; reset abandons any mul with no done pulse.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            result_q <= {WIDTH{1'b0}};
            zero_q   <= 1'b0;
            done_q   <= 1'b0;
            mcand_q  <= {WIDTH{1'b0}};
            mplier_q <= {WIDTH{1'b0}};
            acc_q    <= {WIDTH{1'b0}};
            step_q   <= {STEP_W{1'b0}};
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            done_q   <= done_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            step_q   <= step_d;
        end
    end

    assign bus.result_o = result_q;
    assign bus.zero_o   = zero_q;
    assign bus.done_o   = done_q;
    assign bus.busy_o   = (state_q == S_MUL);

endmodule

// File: doc/exec_unit.md
# exec_unit

Execute-stage arithmetic unit of the pipelined RV32 core. It consumes the 4-bit operation code produced by the ALU control decoder, together with the two 32-bit operands from the ID/EX register. Single-cycle operations return a registered result one cycle later. `mul` runs on an iterative 32-step shift-add engine and raises a stall request so hazard control freezes IF/ID/EX while it runs.

## Interface
Parameters:
- `WIDTH`, 32: operand/result width.
- `MUL_STEPS`, 32: shift-add iterations per `mul`. Must equal `WIDTH`.

Ports:
- `clk_i`  in  1  clock; all state changes on rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `valid_i`  in  1  operation presented this cycle.
- `ctrl_i`  in  4  operation code:
  - 0000 and, 0001 xor, 0010 sll, 0011 add
  - 0100 sub, 0101 mul, 0110 sra
  - any other code is invalid.
- `a_i`  in  WIDTH  operand A (rs1).
- `b_i`  in  WIDTH  operand B (rs2 or immediate).
- `kill_i`  in  1  flush; aborts an in-flight `mul`.
- `result_o`  out  WIDTH  registered result.
- `zero_o`  out  1  registered flag, (result == 0); used for `beq`.
- `done_o`  out  1  one-cycle pulse: `result_o`/`zero_o` updated this cycle.
- `busy_o`  out  1  stall request; high while `mul` iterates.

## Operation
- State machine: IDLE, MUL.
- IDLE, `valid_i`=1, `kill_i`=0, non-mul code: at the edge, load `result_o` and `zero_o` and pulse `done_o`. Stay in IDLE.
- Non-mul results:
  - and/xor/add/sub: bitwise or modulo 2^WIDTH (wrap, no overflow flag).
  - sll: `a_i << b_i[4:0]`.
  - sra: arithmetic right shift of `a_i` by `b_i[4:0]`, sign-filled.
  - invalid code: result 0, `zero_o`=1, `done_o` pulses.
- IDLE, `valid_i`=1, code 0101: at the edge, load the mul registers and go to MUL. Set `busy_o`=1.
  - mcand=a, mplier=b, acc=0, step=0.
  - `result_o`/`zero_o` unchanged, no `done_o`.
- MUL, each edge:
  - If `mplier[0]`, acc += mcand.
  - mcand <<= 1, mplier >>= 1, step++.
  - On the edge where step==MUL_STEPS-1: `result_o` = final acc (low WIDTH bits of a*b; signedness irrelevant), update `zero_o`, pulse `done_o`, `busy_o`=0, go to IDLE.
- No early termination: latency is fixed regardless of operand values.
- MUL ignores `valid_i`. Upstream holds inputs stable while `busy_o`=1.
- `kill_i`=1 in any state:
  - Next edge goes to IDLE, `busy_o`=0, no `done_o`, `result_o`/`zero_o` unchanged.
  - A `valid_i` presented in the same cycle is discarded.
- `rst_i` has priority over `kill_i`, which has priority over `valid_i`.

## Timing
- Reset values: `result_o`=0, `zero_o`=0, `done_o`=0, `busy_o`=0, state IDLE, step=0, mul registers 0.
- Reset mid-`mul`: the operation is abandoned, all outputs take reset values at that edge, and no `done_o` is produced.
- Non-mul latency: 1 cycle.
  - Accepted at edge N; `done_o` high in cycle N..N+1.
  - Back-to-back accepts every cycle give a `done_o` every cycle.
- Mul latency: MUL_STEPS+1 edges.
  - Accept at edge 0; `busy_o` high from after edge 0 until edge MUL_STEPS.
  - `done_o`/`result_o` valid after edge MUL_STEPS, and `busy_o` falls on that same edge.
- A new op may be accepted on the edge right after `done_o` for `mul`.
- `done_o` is never high for two consecutive cycles from a single op.
- `result_o` holds its value between `done_o` pulses.

## Test plan
- Reset, then back-to-back non-mul ops:
  - add 0x7FFFFFFF+1 → 0x80000000, zero=0.
  - sub 5-5 → 0, zero=1.
  - and/xor 0xF0F0F0F0 & / ^ 0xFF00FF00 → 0xF000F000 / 0x0FF00FF0.
  - Each `done_o` exactly one cycle after its accept.
- Shifts:
  - sll 0x1 by b=0x21 (uses 5 bits) → 0x2.
  - sra 0x80000000 by 31 → 0xFFFFFFFF.
  - sra 0x40000000 by 4 → 0x04000000.
- mul 12345×6789 → 83810205 (0x04FED79D):
  - `busy_o` high exactly 32 cycles, `done_o` after edge 32.
  - A second valid op held during busy is not accepted until IDLE.
- mul 0xFFFFFFFF×0xFFFFFFFF → 0x00000001. mul 0×any → 0, zero=1. Latency is still 32 in both cases.
- Abort paths:
  - `kill_i` at step 10 of a mul: `busy_o` low next cycle, no `done_o`, `result_o` keeps its prior value, and a following add completes normally.
  - `rst_i` asserted at step 20 instead: all outputs 0 at that edge.
- Invalid code 1111 with `valid_i` → `done_o` pulse, result 0, zero=1.
